// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-enable divider, h/v counters and registered sync/blanking decode for VGA timing
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          tick, h_wrap, v_wrap;
    logic          p_tick_q, frame_q, hsync_q, vsync_q, video_q;
    logic          hsync_d, vsync_d, video_d;

    // Next counter values; sync/blanking decode from them so the registered flags line up with the registered position
    always_comb begin
        tick    = div_q == DIV_LAST;
        div_d   = tick ? '0 : div_q + 1'b1;
        h_wrap  = tick && x_q == H_LAST;
        v_wrap  = h_wrap && y_q == V_LAST;
        x_d     = tick ? (h_wrap ? '0 : x_q + 1'b1) : x_q;
        y_d     = h_wrap ? (v_wrap ? '0 : y_q + 1'b1) : y_q;
        hsync_d = !(x_d >= HS_START && x_d <= HS_END);
        vsync_d = !(y_d >= VS_START && y_d <= VS_END);
        video_d = x_d < H_DISP && y_d < V_DISP;
    end

    // State and output registers; reset lands on position (0,0) with syncs idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            p_tick_q <= 1'b0;
            frame_q  <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            video_q  <= 1'b1;
        end else begin
            div_q    <= div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            p_tick_q <= tick;
            frame_q  <= v_wrap;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            video_q  <= video_d;
        end
    end

    assign p_tick      = p_tick_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = video_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default-timing and small-override VGA generators checked against an edge-count arithmetic model
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       d_pt, d_von, d_hs, d_vs, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_pt, s_von, s_hs, s_vs, s_fs;
    logic [9:0] s_x, s_y;

    vga_sync_gen dut_d (
        .clk(clk), .reset(reset), .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y),
        .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_s (
        .clk(clk), .reset(reset), .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y),
        .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
    );

    logic [24:0] obs_d, obs_s;
    assign obs_d = {d_pt, d_x, d_y, d_von, d_hs, d_vs, d_fs};
    assign obs_s = {s_pt, s_x, s_y, s_von, s_hs, s_vs, s_fs};
    localparam logic [24:0] RST_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};

    int edges;
    int checks = 0;
    int errors = 0;

    // Rising edges seen since reset was last released
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else edges <= edges + 1;
    end

    // After n edges the generator has issued n/cd pixel ticks; position and flags follow from that count alone
    function automatic logic [24:0] model(int n, int cd, int hd, int hf, int hsw, int hb,
                                          int vd, int vf, int vsw, int vb);
        int ht, vt, p, x, y;
        logic pt, fs, hs, vs, von;
        ht  = hd + hf + hsw + hb;
        vt  = vd + vf + vsw + vb;
        p   = n / cd;
        x   = p % ht;
        y   = (p / ht) % vt;
        pt  = n > 0 && n % cd == 0;
        fs  = pt && p % (ht * vt) == 0;
        hs  = !(x >= hd + hf && x < hd + hf + hsw);
        vs  = !(y >= vd + vf && y < vd + vf + vsw);
        von = x < hd && y < vd;
        return {pt, 10'(x), 10'(y), von, hs, vs, fs};
    endfunction

    function automatic logic [24:0] exp_d(int n);
        return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [24:0] exp_s(int n);
        return model(n, 2, 8, 2, 2, 2, 4, 1, 1, 1);
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 2;
            if (obs_d !== RST_VEC) begin errors++; $display("FAIL reset_hold_d: got %h expected %h", obs_d, RST_VEC); end
            if (obs_s !== RST_VEC) begin errors++; $display("FAIL reset_hold_s: got %h expected %h", obs_s, RST_VEC); end
        end
        #1 reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks += 2;
            if (obs_d !== exp_d(edges)) begin errors++; $display("FAIL release_d edge %0d: got %h expected %h", i, obs_d, exp_d(edges)); end
            if (obs_s !== exp_s(edges)) begin errors++; $display("FAIL release_s edge %0d: got %h expected %h", i, obs_s, exp_s(edges)); end
            if (i == 4) begin
                checks++;
                if (d_pt !== 1'b1 || d_x !== 10'd1) begin
                    errors++; $display("FAIL first_tick: got p_tick=%b x=%0d expected p_tick=1 x=1", d_pt, d_x);
                end
            end
        end
    endtask

    task automatic test_lines();
        int hs_low = 0, v_fall = 0, y_inc = 0;
        logic pv = 1'b0;
        logic [9:0] px = '0, py = '0;
        for (int i = 0; i < 6400; i++) begin
            @(negedge clk);
            checks += 2;
            if (obs_d !== exp_d(edges)) begin errors++; $display("FAIL lines_d edge %0d: got %h expected %h", edges, obs_d, exp_d(edges)); end
            if (obs_s !== exp_s(edges)) begin errors++; $display("FAIL lines_s edge %0d: got %h expected %h", edges, obs_s, exp_s(edges)); end
            if (i < 3200 && !d_hs) hs_low++;
            if (px == 10'd639 && d_x == 10'd640 && pv && !d_von) v_fall++;
            if (px == 10'd799 && d_x == 10'd0 && d_y == py + 10'd1) y_inc++;
            pv = d_von; px = d_x; py = d_y;
        end
        checks += 3;
        if (hs_low != 384) begin errors++; $display("FAIL hsync_width: got %0d clks expected 384", hs_low); end
        if (v_fall != 2) begin errors++; $display("FAIL video_fall: got %0d expected 2", v_fall); end
        if (y_inc != 2) begin errors++; $display("FAIL line_advance: got %0d expected 2", y_inc); end
    endtask

    task automatic test_mid_reset();
        int budget = 0;
        while (d_x != 10'd700 && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (d_x != 10'd700) begin errors++; $display("FAIL reach_700: got x=%0d expected 700", d_x); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 2;
        if (obs_d !== RST_VEC) begin errors++; $display("FAIL async_reset_d: got %h expected %h", obs_d, RST_VEC); end
        if (obs_s !== RST_VEC) begin errors++; $display("FAIL async_reset_s: got %h expected %h", obs_s, RST_VEC); end
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= 3300; i++) begin
            @(negedge clk);
            checks += 2;
            if (obs_d !== exp_d(edges)) begin errors++; $display("FAIL restart_d edge %0d: got %h expected %h", edges, obs_d, exp_d(edges)); end
            if (obs_s !== exp_s(edges)) begin errors++; $display("FAIL restart_s edge %0d: got %h expected %h", edges, obs_s, exp_s(edges)); end
            if (i == 4) begin
                checks++;
                if (d_pt !== 1'b1 || d_x !== 10'd1) begin
                    errors++; $display("FAIL restart_tick: got p_tick=%b x=%0d expected p_tick=1 x=1", d_pt, d_x);
                end
            end
        end
    endtask

    task automatic test_frames_small();
        int fs_cnt = 0, vs_low = 0;
        for (int i = 0; i < 196 * 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_s !== exp_s(edges)) begin errors++; $display("FAIL frames_s edge %0d: got %h expected %h", edges, obs_s, exp_s(edges)); end
            if (s_fs) fs_cnt++;
            if (!s_vs) vs_low++;
        end
        checks += 2;
        if (fs_cnt != 3) begin errors++; $display("FAIL frame_count: got %0d expected 3", fs_cnt); end
        if (vs_low != 84) begin errors++; $display("FAIL vsync_width_s: got %0d clks expected 84", vs_low); end
    endtask

    task automatic test_random_resets();
        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(50, 800));
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                checks += 2;
                if (obs_d !== exp_d(edges)) begin errors++; $display("FAIL rand_d edge %0d: got %h expected %h", edges, obs_d, exp_d(edges)); end
                if (obs_s !== exp_s(edges)) begin errors++; $display("FAIL rand_s edge %0d: got %h expected %h", edges, obs_s, exp_s(edges)); end
            end
            #($urandom_range(1, 3) + ($urandom_range(0, 1) == 1 ? 5 : 0));
            reset = 1'b1;
            #1;
            checks += 2;
            if (obs_d !== RST_VEC) begin errors++; $display("FAIL rand_reset_d: got %h expected %h", obs_d, RST_VEC); end
            if (obs_s !== RST_VEC) begin errors++; $display("FAIL rand_reset_s: got %h expected %h", obs_s, RST_VEC); end
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #1 reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_lines();
        test_mid_reset();
        test_frames_small();
        test_random_resets();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing master for the VGA display path. Generates the pixel enable, the horizontal and vertical counters, the sync pulses and the active-video flag.
- Object renderers (hoop, ball, background) consume pixel_x, pixel_y and video_on directly. hsync and vsync drive the VGA connector.
- Also emits a one-clock frame_start pulse. Game/physics logic uses it to update object positions once per frame.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz to 25 MHz); minimum 2.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- p_tick  output  1  one-clk pixel enable, once every CLK_DIV clocks.
- pixel_x  output  10  current column, 0..H_TOTAL-1.
- pixel_y  output  10  current line, 0..V_TOTAL-1.
- video_on  output  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- frame_start  output  1  one-clk pulse when the counters enter (0,0).

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: div_cnt=0, pixel_x=0, pixel_y=0, p_tick=0, frame_start=0, hsync=1, vsync=1, video_on=1 (consistent with position (0,0)).
- Reset mid-frame: all state returns to these values immediately, without waiting for a clock edge.
- All outputs are registered. hsync, vsync and video_on are computed from the next counter values, so on every clock they match the pixel_x/pixel_y they are presented with. No combinational glitches on the sync pins.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - p_tick register is 1 on the clock after div_cnt==CLK_DIV-1, otherwise 0.
  - First p_tick after reset release is asserted on the CLK_DIV-th rising edge.
- Horizontal counter:
  - Advances only on clocks where the internal tick condition (div_cnt==CLK_DIV-1) holds, i.e. updates coincide with p_tick going high.
  - pixel_x increments by 1; at H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - pixel_y increments only when pixel_x wraps; at V_TOTAL-1 it wraps to 0.
  - Simultaneous wrap at (H_TOTAL-1, V_TOTAL-1) goes to (0,0) in a single update.
- Pixel hold: pixel_x and pixel_y hold steady for exactly CLK_DIV clocks per pixel.
- Sync decode:
  - hsync = 0 iff H_DISPLAY+H_FRONT <= pixel_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync = 0 iff V_DISPLAY+V_FRONT <= pixel_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
  - vsync is a function of pixel_y only, so it changes at the start of a line.
- frame_start: 1 for exactly one clock, on the update that moves the counters to (0,0). It is not asserted by reset itself.
- Widths: all counters are 10-bit unsigned. Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024. No other overflow cases exist.

Test Plan:
- Reset release: hold reset 5 clks, release. During reset: pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, p_tick=0. First p_tick on the 4th edge after release; pixel_x=1 at the same edge.
- Pixel/line timing: run 2 lines. p_tick period is 4 clks. pixel_x goes 639->640 with video_on 1->0. hsync low from pixel_x=656 through 751, i.e. 96 pixels = 384 clks. Line period is 3200 clks. pixel_y increments when pixel_x goes 799->0.
- Vertical timing: vsync low exactly for pixel_y=490 and 491 (1600 p_ticks). video_on is 0 for all pixel_y >= 480.
- Frame wrap: at (799,524) the next update gives (0,0) with frame_start high for 1 clk. Frame period is 420000 p_ticks = 1,680,000 clks. frame_start never pulses mid-frame.
- Reset mid-frame: assert reset asynchronously (between edges) at pixel (700,300). Outputs return to reset values immediately. After release, timing restarts exactly as in the reset-release scenario.
- Parameter override: CLK_DIV=2 with small totals (e.g. H 8/2/2/2, V 4/1/1/1). Check p_tick period 2, H_TOTAL=14, V_TOTAL=7, and hsync/vsync windows at 10..11 and 5..5.
